// File: rtl/cnn16_pkg.sv
// rtl/cnn16_pkg.sv - shared widths and transfer FSM state type for the CNN16 data memory
//
// Purpose: common definitions for cnn16_mem_ctrl and its RAM.
//   DATA_W     memory word width
//   ADDR_W     word address width (depth = 2**ADDR_W)
//   ADDR_ONE   address-width constant 1 for pointer/count arithmetic
//   xf_state_t transfer engine states
package cnn16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } xf_state_t;

endpackage

// File: rtl/cnn16_ram_sp.sv
// rtl/cnn16_ram_sp.sv - single-port synchronous read-first RAM, no reset
//
// Purpose: 2**ADDR_W x DATA_W storage with a registered read port.
// Ports:
//   i_clk    clock, rising edge
//   i_en     port enable; o_rdata updates only on enabled cycles
//   i_we     write enable (qualified by i_en)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  read data, one cycle after the enabled access (old data on a write)
module cnn16_ram_sp
  import cnn16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Read-first: the read samples the array before the write lands.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cnn16_mem_ctrl.sv
// rtl/cnn16_mem_ctrl.sv - CNN16 4K x 16 data memory with stream loader and dumper
//
// Purpose: CPU-side synchronous data memory; a stream engine can take the RAM to
// preload words from a valid/ready source (LOAD) or drain words to a valid/ready
// sink (DUMP). While the engine owns the RAM the CPU side is stalled.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_cpu_addr/wdata/we/re        CPU word access (honoured in IDLE only)
//   o_cpu_rdata                   CPU read data, 1-cycle latency, holds otherwise
//   o_cpu_stall                   RAM owned by the stream engine
//   i_ld_start, i_dp_start        start load / dump (1-cycle pulses)
//   i_xf_base, i_xf_len           transfer base address and word count
//   i_s_valid/i_s_data/o_s_ready  load stream
//   o_m_valid/o_m_data/i_m_ready  dump stream
//   o_xf_busy, o_xf_done          transfer in progress / completion pulse
module cnn16_mem_ctrl
  import cnn16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_we,
  input  logic              i_cpu_re,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_ld_start,
  input  logic              i_dp_start,
  input  logic [ADDR_W-1:0] i_xf_base,
  input  logic [ADDR_W-1:0] i_xf_len,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_m_valid,
  output logic [DATA_W-1:0] o_m_data,
  input  logic              i_m_ready,
  output logic              o_xf_busy,
  output logic              o_xf_done
);

  xf_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_count;      // words still to write (LOAD) or deliver (DUMP)
  logic [ADDR_W-1:0] r_issue_cnt;  // DUMP: RAM reads still to issue
  logic              r_s_ready;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_rd_inflight;
  logic              r_cpu_rd;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_busy;
  logic              r_done;

  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_ld_beat;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_held_next;

  assign w_ld_beat = (r_state == LOAD) && i_s_valid && r_s_ready;
  assign w_pop     = r_m_valid && i_m_ready;

  // Words held in the output register + skid after this edge. A new read is only
  // issued if its data (arriving one cycle later) is guaranteed a free slot even
  // when the sink stalls, so the two-entry output stage can never overflow.
  assign w_held_next = {1'b0, r_m_valid} + {1'b0, r_skid_valid}
                     + {1'b0, r_rd_inflight} - {1'b0, w_pop};
  assign w_issue     = (r_state == DUMP) && (r_issue_cnt != '0) && (w_held_next <= 2'd1);

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_ptr;
    w_ram_wdata = i_s_data;
    case (r_state)
      IDLE: begin
        w_ram_en    = i_cpu_we || i_cpu_re;
        w_ram_we    = i_cpu_we;
        w_ram_addr  = i_cpu_addr;
        w_ram_wdata = i_cpu_wdata;
      end
      LOAD: begin
        w_ram_en = w_ld_beat;
        w_ram_we = w_ld_beat;
      end
      DUMP: begin
        w_ram_en = w_issue;
      end
      default: ;
    endcase
  end

  cnn16_ram_sp u_ram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_count       <= '0;
      r_issue_cnt   <= '0;
      r_s_ready     <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= '0;
      r_rd_inflight <= 1'b0;
      r_cpu_rd      <= 1'b0;
      r_cpu_rdata   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // The RAM output register is shared with the dumper, so CPU read data is
      // captured locally to keep o_cpu_rdata stable across later transfers.
      r_cpu_rd      <= (r_state == IDLE) && i_cpu_re;
      if (r_cpu_rd) begin
        r_cpu_rdata <= w_ram_rdata;
      end
      r_rd_inflight <= w_issue;

      case (r_state)
        IDLE: begin
          if (i_ld_start || i_dp_start) begin
            r_ptr   <= i_xf_base;
            r_count <= i_xf_len;
            r_busy  <= 1'b1;
            if (i_xf_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (i_ld_start) begin
              r_state   <= LOAD;
              r_s_ready <= 1'b1;
            end else begin
              r_state     <= DUMP;
              r_issue_cnt <= i_xf_len;
            end
          end
        end

        LOAD: begin
          if (w_ld_beat) begin
            r_ptr   <= r_ptr + ADDR_ONE;
            r_count <= r_count - ADDR_ONE;
            if (r_count == ADDR_ONE) begin
              r_state   <= DONE;
              r_s_ready <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end

        DUMP: begin
          if (w_issue) begin
            r_ptr       <= r_ptr + ADDR_ONE;
            r_issue_cnt <= r_issue_cnt - ADDR_ONE;
          end
          // Output register refills from the skid first (older word), then from
          // the RAM; RAM data that cannot enter the output register parks in skid.
          if (!r_m_valid || w_pop) begin
            if (r_skid_valid) begin
              r_m_data     <= r_skid_data;
              r_m_valid    <= 1'b1;
              r_skid_valid <= r_rd_inflight;
              r_skid_data  <= w_ram_rdata;
            end else if (r_rd_inflight) begin
              r_m_data  <= w_ram_rdata;
              r_m_valid <= 1'b1;
            end else begin
              r_m_valid <= 1'b0;
            end
          end else if (r_rd_inflight) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_ram_rdata;
          end
          if (w_pop) begin
            r_count <= r_count - ADDR_ONE;
            if (r_count == ADDR_ONE) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_m_valid <= 1'b0;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rd ? w_ram_rdata : r_cpu_rdata;
  assign o_cpu_stall = r_busy;
  assign o_xf_busy   = r_busy;
  assign o_xf_done   = r_done;
  assign o_s_ready   = r_s_ready;
  assign o_m_valid   = r_m_valid;
  assign o_m_data    = r_m_data;

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// tb/tb_cnn16_mem_ctrl.sv - self-checking bench for cnn16_mem_ctrl
module tb_cnn16_mem_ctrl;

  logic        clk;
  logic        i_rst;
  logic [11:0] i_cpu_addr;
  logic [15:0] i_cpu_wdata;
  logic        i_cpu_we;
  logic        i_cpu_re;
  logic [15:0] o_cpu_rdata;
  logic        o_cpu_stall;
  logic        i_ld_start;
  logic        i_dp_start;
  logic [11:0] i_xf_base;
  logic [11:0] i_xf_len;
  logic        i_s_valid;
  logic [15:0] i_s_data;
  logic        o_s_ready;
  logic        o_m_valid;
  logic [15:0] o_m_data;
  logic        i_m_ready;
  logic        o_xf_busy;
  logic        o_xf_done;

  cnn16_mem_ctrl dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_re    (i_cpu_re),
    .o_cpu_rdata (o_cpu_rdata),
    .o_cpu_stall (o_cpu_stall),
    .i_ld_start  (i_ld_start),
    .i_dp_start  (i_dp_start),
    .i_xf_base   (i_xf_base),
    .i_xf_len    (i_xf_len),
    .i_s_valid   (i_s_valid),
    .i_s_data    (i_s_data),
    .o_s_ready   (o_s_ready),
    .o_m_valid   (o_m_valid),
    .o_m_data    (o_m_data),
    .i_m_ready   (i_m_ready),
    .o_xf_busy   (o_xf_busy),
    .o_xf_done   (o_xf_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] ref_mem [4096];
  logic [15:0] ld_q [$];
  logic [15:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks enter and leave on a falling edge.
  task automatic cpu_access(input logic [11:0] a, input logic we, input logic [15:0] d,
                            input logic re, output logic [15:0] q);
    i_cpu_addr = a; i_cpu_wdata = d; i_cpu_we = we; i_cpu_re = re;
    @(negedge clk);
    i_cpu_we = 1'b0; i_cpu_re = 1'b0;
    q = o_cpu_rdata;
    if (we) ref_mem[a] = d;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [11:0] a);
    logic [15:0] q;
    cpu_access(a, 1'b0, 16'h0, 1'b1, q);
    chk(tag, q, ref_mem[a]);
  endtask

  // Load ld_q to base; gap_at forces a 2-cycle s_valid gap before that beat,
  // cpu_wr holds a CPU write active throughout, abort_at resets after that many beats.
  task automatic do_load(input logic [11:0] base, input int len, input int gap_at,
                         input bit cpu_wr, input bit both, input int abort_at);
    int k, cyc, gap_left;
    bit gapped, v;
    k = 0; cyc = 0; gap_left = 0; gapped = 0;
    i_xf_base = base; i_xf_len = 12'(len); i_ld_start = 1'b1; i_dp_start = both;
    @(negedge clk);
    i_ld_start = 1'b0; i_dp_start = 1'b0;
    while (k < len && cyc < 300) begin
      if (abort_at == k) begin
        i_rst = 1'b1;
        #1;
        chk("rst_s_ready", o_s_ready, 1'b0);
        chk("rst_busy", o_xf_busy, 1'b0);
        chk("rst_stall", o_cpu_stall, 1'b0);
        chk("rst_done", o_xf_done, 1'b0);
        chk("rst_m_valid", o_m_valid, 1'b0);
        chk("rst_cpu_rdata", o_cpu_rdata, 16'h0);
        i_s_valid = 1'b0; i_cpu_we = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_idle_busy", o_xf_busy, 1'b0);
        chk("rst_no_done", o_xf_done, 1'b0);
        return;
      end
      if (k == gap_at && !gapped) begin gapped = 1; gap_left = 2; end
      if (gap_left > 0) begin v = 0; gap_left--; end
      else v = ($urandom_range(3) != 0);
      i_s_valid = v;
      i_s_data  = v ? ld_q[k] : 16'($urandom);
      if (cpu_wr) begin
        chk("ld_stall", o_cpu_stall, 1'b1);
        i_cpu_we = 1'b1; i_cpu_addr = 12'h100; i_cpu_wdata = 16'hBEEF;
      end
      if (v && o_s_ready) begin
        ref_mem[12'(base + 12'(k))] = ld_q[k];
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    i_s_valid = 1'b0; i_cpu_we = 1'b0;
    if (cyc >= 300) chk("ld_timeout", 32'(k), 32'(len));
    chk("ld_done", o_xf_done, 1'b1);
    chk("ld_s_ready_off", o_s_ready, 1'b0);
    @(negedge clk);
    chk("ld_done_pulse", o_xf_done, 1'b0);
    chk("ld_idle", o_xf_busy, 1'b0);
  endtask

  task automatic do_dump(input logic [11:0] base, input int len, input bit always_rdy);
    logic [15:0] exp_q [$];
    logic [15:0] prev_d;
    int got, cyc, first, last;
    bit prev_stall, r;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[12'(base + 12'(i))]);
    got = 0; cyc = 0; first = 0; last = 0; prev_stall = 0; prev_d = '0;
    i_xf_base = base; i_xf_len = 12'(len); i_dp_start = 1'b1;
    @(negedge clk);
    i_dp_start = 1'b0;
    while (got < len && cyc < 400) begin
      if (prev_stall) begin
        chk("dp_hold_valid", o_m_valid, 1'b1);
        chk("dp_hold_data", o_m_data, prev_d);
      end
      // A start while busy must be ignored.
      i_ld_start = (cyc == 2);
      i_xf_len   = (cyc == 2) ? 12'd1 : 12'(len);
      r = always_rdy ? 1'b1 : 1'($urandom_range(1));
      i_m_ready = r;
      if (o_m_valid && r) begin
        chk("dp_data", o_m_data, exp_q[got]);
        if (got == 0) first = cyc;
        last = cyc;
        got++;
      end
      prev_stall = o_m_valid && !r;
      prev_d = o_m_data;
      @(negedge clk);
      cyc++;
    end
    i_m_ready = 1'b0; i_ld_start = 1'b0;
    if (cyc >= 400) chk("dp_timeout", 32'(got), 32'(len));
    if (always_rdy && len > 0) chk("dp_back_to_back", 32'(last - first), 32'(len - 1));
    chk("dp_done", o_xf_done, 1'b1);
    chk("dp_no_extra", o_m_valid, 1'b0);
    @(negedge clk);
    chk("dp_done_pulse", o_xf_done, 1'b0);
    chk("dp_idle", o_xf_busy, 1'b0);
    chk("dp_s_ready", o_s_ready, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_cpu_addr = '0; i_cpu_wdata = '0; i_cpu_we = 0; i_cpu_re = 0;
    i_ld_start = 0; i_dp_start = 0; i_xf_base = '0; i_xf_len = '0;
    i_s_valid = 0; i_s_data = '0; i_m_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_cpu_rdata", o_cpu_rdata, 16'h0);
    chk("reset_stall", o_cpu_stall, 1'b0);
    chk("reset_s_ready", o_s_ready, 1'b0);
    chk("reset_m_valid", o_m_valid, 1'b0);
    chk("reset_m_data", o_m_data, 16'h0);
    chk("reset_busy", o_xf_busy, 1'b0);
    chk("reset_done", o_xf_done, 1'b0);
    i_rst = 1'b0;
    @(negedge clk);

    // CPU write, read-first collision, hold
    cpu_access(12'h100, 1'b1, 16'h1111, 1'b0, rd);
    cpu_access(12'h100, 1'b1, 16'h1234, 1'b1, rd);
    chk("cpu_read_first", rd, 16'h1111);
    cpu_read_chk("cpu_read_new", 12'h100);
    chk("cpu_read_new_const", o_cpu_rdata, 16'h1234);
    @(negedge clk);
    chk("cpu_rdata_hold", o_cpu_rdata, 16'h1234);

    // Directed load with a 2-cycle gap
    ld_q = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    do_load(12'h010, 4, 2, 0, 0, -1);
    cpu_access(12'h012, 1'b0, 16'h0, 1'b1, rd);
    chk("load_rd_012", rd, 16'h00A3);

    // Wrapping load
    ld_q = '{16'h0001, 16'h0002, 16'h0003};
    do_load(12'hFFE, 3, -1, 0, 0, -1);
    cpu_access(12'hFFE, 1'b0, 16'h0, 1'b1, rd); chk("wrap_ffe", rd, 16'h0001);
    cpu_access(12'hFFF, 1'b0, 16'h0, 1'b1, rd); chk("wrap_fff", rd, 16'h0002);
    cpu_access(12'h000, 1'b0, 16'h0, 1'b1, rd); chk("wrap_000", rd, 16'h0003);

    // Dumps: random backpressure, full rate, wrapping
    do_dump(12'h010, 4, 0);
    do_dump(12'h010, 4, 1);
    do_dump(12'hFFE, 3, 0);
    chk("cpu_rdata_after_dump", o_cpu_rdata, 16'h0003);

    // CPU write during LOAD is dropped
    ld_q = '{16'h5A5A, 16'hA5A5};
    do_load(12'h200, 2, -1, 1, 0, -1);
    cpu_read_chk("stalled_we_dropped", 12'h100);
    chk("stalled_we_const", o_cpu_rdata, 16'h1234);

    // Simultaneous starts: load wins
    ld_q = '{16'hC0DE};
    do_load(12'h300, 1, -1, 0, 1, -1);
    cpu_read_chk("both_start_load", 12'h300);

    // Empty transfers
    do_load(12'h050, 0, -1, 0, 0, -1);
    do_dump(12'h050, 0, 0);

    // Randomised load/dump and CPU traffic
    for (int it = 0; it < 6; it++) begin
      logic [11:0] b;
      int n;
      b = 12'($urandom);
      n = $urandom_range(16, 1);
      ld_q.delete();
      for (int i = 0; i < n; i++) ld_q.push_back(16'($urandom));
      do_load(b, n, $urandom_range(n - 1), 0, 0, -1);
      do_dump(b, n, 1'($urandom_range(1)));
      cpu_read_chk("rand_cpu_rd", 12'(b + 12'(n - 1)));
    end
    for (int it = 0; it < 6; it++) begin
      logic [11:0] a;
      a = 12'($urandom);
      cpu_access(a, 1'b1, 16'($urandom), 1'b0, rd);
      cpu_read_chk("rand_cpu_wr", a);
    end

    // Reset mid-load after 2 of 4 beats
    cpu_read_chk("pre_rst_rd", 12'h100);
    ld_q = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
    do_load(12'h400, 4, -1, 0, 0, 2);
    cpu_access(12'h400, 1'b0, 16'h0, 1'b1, rd); chk("rst_kept_0", rd, 16'h7001);
    cpu_access(12'h401, 1'b0, 16'h0, 1'b1, rd); chk("rst_kept_1", rd, 16'h7002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
